// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the multi-road traffic controller:
//   - phase_e    : intersection phase encoding
//   - RED/YEL/GRN: per-road {red,yellow,green} light codes
//   - lowest_set : priority encoder (lowest set index) used for emergencies
//   - max_int    : helper used to size the phase timer
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN     = 2'd0,
    YELLOW    = 2'd1,
    ALL_RED   = 2'd2,
    EMG_GREEN = 2'd3
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Widest request vector the priority encoder accepts (caps NUM_ROADS).
  localparam int MAX_ROADS = 32;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify
  // the result with a separate "any request" term).
  function automatic int lowest_set(input logic [MAX_ROADS-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_ROADS - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tc_phase_timer.sv
// -----------------------------------------------------------------------------
// tc_phase_timer
// Loadable down-counter that times one intersection phase. A phase of T
// cycles is started by loading T-1; the count then falls by one per cycle
// and rests at zero. done_o flags the final cycle of the phase.
//   clk        : system clock (1 cycle = 1 s)
//   rst_n      : asynchronous active-low reset, count returns to RST_VAL
//   load_i     : load load_val_i on the next edge (overrides counting)
//   load_val_i : value to load (phase length minus one)
//   count_o    : cycles remaining in the current phase after this one
//   done_o     : high while count_o is zero
// -----------------------------------------------------------------------------
module tc_phase_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic [TW-1:0] count_o,
  output logic          done_o
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= RST_VAL;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/multi_road_traffic_controller.sv
// -----------------------------------------------------------------------------
// multi_road_traffic_controller
// N-road intersection controller. Roads are served round-robin through
// GREEN -> YELLOW -> ALL_RED. Pedestrian presses are latched per road and
// granted as a walk window at the start of another road's green. Emergency
// presses are latched per road and preempt normal rotation, lowest index
// first, with an EMG_GREEN phase.
//   clk         : 1 Hz system tick, one cycle = one second
//   reset       : asynchronous, active-low
//   emergency   : per-road emergency request (pulse or level)
//   ped_button  : per-road pedestrian request (pulse or level)
//   lights      : per-road {red,yellow,green}, road i at [3i+2:3i]
//   walk        : walk signal for crossing road i
//   buzzer      : warning during the last BUZZ_T cycles of walk[i]
//   active_road : index of the road owning the current phase
//   emg_active  : high while an emergency green is served
// -----------------------------------------------------------------------------
module multi_road_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS = 2,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int BUZZ_T    = 2,
  parameter int EMG_T     = 8,
  localparam int IDXW     = $clog2(NUM_ROADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ROADS-1:0]   emergency,
  input  logic [NUM_ROADS-1:0]   ped_button,
  output logic [3*NUM_ROADS-1:0] lights,
  output logic [NUM_ROADS-1:0]   walk,
  output logic [NUM_ROADS-1:0]   buzzer,
  output logic [IDXW-1:0]        active_road,
  output logic                   emg_active
);

  localparam int MAX_T = max_int(max_int(GREEN_T, YELLOW_T), max_int(ALLRED_T, EMG_T));
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef logic [TW-1:0]        tval_t;
  typedef logic [NUM_ROADS-1:0] rmask_t;
  typedef logic [IDXW-1:0]      ridx_t;

  localparam tval_t GREEN_LD  = tval_t'(GREEN_T - 1);
  localparam tval_t YELLOW_LD = tval_t'(YELLOW_T - 1);
  localparam tval_t ALLRED_LD = tval_t'(ALLRED_T - 1);
  localparam tval_t EMG_LD    = tval_t'(EMG_T - 1);
  // The green timer counts down from GREEN_T-1, so the first WALK_T cycles
  // of green are those with count >= WALK_EDGE, and the buzzer covers the
  // lowest BUZZ_T counts of that window.
  localparam tval_t WALK_EDGE = tval_t'(GREEN_T - WALK_T);
  localparam tval_t BUZZ_EDGE = tval_t'(GREEN_T - WALK_T + BUZZ_T - 1);
  localparam ridx_t LAST_ROAD = ridx_t'(NUM_ROADS - 1);

  phase_e state_q, state_d;
  ridx_t  road_q, road_d;
  rmask_t ped_req_q, ped_req_d;
  rmask_t emg_req_q, emg_req_d;
  rmask_t grant_q, grant_d;

  logic   tmr_load, tmr_done;
  tval_t  tmr_val, tmr_count;

  tc_phase_timer #(
    .TW      (TW),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  // Requests present this edge count as latched, so a press on the exiting
  // cycle is honoured by the transition it coincides with.
  rmask_t ped_pend, emg_pend;
  ridx_t  emg_idx, next_road;
  rmask_t emg_mask, road_mask, next_mask;
  logic   walk_win, buzz_win;

  assign ped_pend  = ped_req_q | ped_button;
  assign emg_pend  = emg_req_q | emergency;
  assign emg_idx   = ridx_t'(lowest_set(32'(emg_pend)));
  assign next_road = (road_q == LAST_ROAD) ? '0 : road_q + ridx_t'(1);
  assign emg_mask  = rmask_t'(1) << emg_idx;
  assign road_mask = rmask_t'(1) << road_q;
  assign next_mask = rmask_t'(1) << next_road;

  assign walk_win  = (state_q == GREEN) && (tmr_count >= WALK_EDGE);
  assign buzz_win  = walk_win && (tmr_count <= BUZZ_EDGE);
  assign walk      = walk_win ? grant_q : '0;
  assign buzzer    = buzz_win ? grant_q : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d   = state_q;
    road_d    = road_q;
    ped_req_d = ped_pend;
    emg_req_d = emg_pend;
    grant_d   = grant_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      GREEN: begin
        if (|emg_pend) begin
          // Preemption: interrupted walks go back into the request latch.
          ped_req_d = ped_pend | walk;
          grant_d   = '0;
          tmr_load  = 1'b1;
          if (emg_idx == road_q) begin
            state_d   = EMG_GREEN;
            tmr_val   = EMG_LD;
            emg_req_d = emg_pend & ~emg_mask;
          end else begin
            state_d   = YELLOW;
            tmr_val   = YELLOW_LD;
          end
        end else if (tmr_done) begin
          state_d  = YELLOW;
          grant_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = YELLOW_LD;
        end
      end

      YELLOW: begin
        if (tmr_done) begin
          state_d  = ALL_RED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end
      end

      ALL_RED: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (|emg_pend) begin
            state_d   = EMG_GREEN;
            road_d    = emg_idx;
            tmr_val   = EMG_LD;
            emg_req_d = emg_pend & ~emg_mask;
          end else begin
            // Grant every crossing except the road turning green; that
            // road's request waits for another road's green.
            state_d   = GREEN;
            road_d    = next_road;
            tmr_val   = GREEN_LD;
            grant_d   = ped_pend & ~next_mask;
            ped_req_d = ped_pend & next_mask;
          end
        end
      end

      EMG_GREEN: begin
        // A repeat request from the served road extends the phase instead
        // of queueing a second service.
        emg_req_d = emg_pend & ~road_mask;
        if (|(emergency & road_mask)) begin
          tmr_load = 1'b1;
          tmr_val  = EMG_LD;
        end else if (tmr_done) begin
          state_d  = YELLOW;
          tmr_load = 1'b1;
          tmr_val  = YELLOW_LD;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ALL_RED;
      road_q    <= LAST_ROAD;
      ped_req_q <= '0;
      emg_req_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      road_q    <= road_d;
      ped_req_q <= ped_req_d;
      emg_req_q <= emg_req_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROADS; i++) begin
      lights[3*i +: 3] = RED;
      if (road_q == ridx_t'(i)) begin
        case (state_q)
          GREEN, EMG_GREEN: lights[3*i +: 3] = GRN;
          YELLOW:           lights[3*i +: 3] = YEL;
          default:          ;
        endcase
      end
    end
  end

  assign active_road = road_q;
  assign emg_active  = (state_q == EMG_GREEN);

endmodule

// File: tb/tb_multi_road_traffic_controller.sv
// -----------------------------------------------------------------------------
// tb_multi_road_traffic_controller
// Drives a 2-road and a 4-road controller (default timings) from one clock
// and reset. A phase/age model built directly from the intersection rules
// predicts every output each cycle; directed hand-computed expectations at
// chosen cycles pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_multi_road_traffic_controller;

  localparam int GREEN_T = 10, YELLOW_T = 3, ALLRED_T = 1;
  localparam int WALK_T = 6, BUZZ_T = 2, EMG_T = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  emg2 = '0, ped2 = '0, w2, b2;
  logic [5:0]  l2;
  logic [0:0]  ar2;
  logic        ea2;
  logic [3:0]  emg4 = '0, ped4 = '0, w4, b4;
  logic [11:0] l4;
  logic [1:0]  ar4;
  logic        ea4;

  multi_road_traffic_controller #(.NUM_ROADS(2)) dut2 (
    .clk(clk), .reset(reset), .emergency(emg2), .ped_button(ped2),
    .lights(l2), .walk(w2), .buzzer(b2), .active_road(ar2), .emg_active(ea2)
  );

  multi_road_traffic_controller #(.NUM_ROADS(4)) dut4 (
    .clk(clk), .reset(reset), .emergency(emg4), .ped_button(ped4),
    .lights(l4), .walk(w4), .buzzer(b4), .active_road(ar4), .emg_active(ea4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Phase kind + road + cycles already spent in the phase (age).
  localparam int K_GRN = 0, K_YEL = 1, K_RED = 2, K_EMG = 3;

  typedef struct {
    int         n;
    int         kind;
    int         road;
    int         age;
    logic [3:0] ped;
    logic [3:0] emg;
    logic [3:0] grant;
  } mdl_t;

  function automatic int dur(input int kind);
    case (kind)
      K_GRN:   return GREEN_T;
      K_YEL:   return YELLOW_T;
      K_RED:   return ALLRED_T;
      default: return EMG_T;
    endcase
  endfunction

  function automatic mdl_t m_reset(input int n);
    mdl_t m;
    m.n = n; m.kind = K_RED; m.road = n - 1; m.age = 0;
    m.ped = '0; m.emg = '0; m.grant = '0;
    return m;
  endfunction

  function automatic logic [3:0] m_walk(input mdl_t m);
    if (m.kind == K_GRN && m.age < WALK_T) return m.grant;
    return 4'b0;
  endfunction

  function automatic logic [3:0] m_buzz(input mdl_t m);
    if (m.kind == K_GRN && m.age >= WALK_T - BUZZ_T && m.age < WALK_T) return m.grant;
    return 4'b0;
  endfunction

  function automatic logic [11:0] m_lights(input mdl_t m);
    logic [11:0] l;
    l = '0;
    for (int i = 0; i < m.n; i++) begin
      l[3*i +: 3] = 3'b100;
      if (i == m.road && m.kind != K_RED) l[3*i +: 3] = (m.kind == K_YEL) ? 3'b010 : 3'b001;
    end
    return l;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input logic [3:0] e_in, input logic [3:0] p_in);
    mdl_t       r;
    logic [3:0] valid, pe, pp;
    int         e;
    bit         last;
    r     = m;
    valid = 4'((1 << m.n) - 1);
    pe    = (m.emg | e_in) & valid;
    pp    = (m.ped | p_in) & valid;
    e     = -1;
    for (int i = m.n - 1; i >= 0; i--) if (pe[i]) e = i;
    last  = (m.age == dur(m.kind) - 1);
    r.age = m.age + 1;
    r.emg = pe;
    r.ped = pp;
    case (m.kind)
      K_GRN: begin
        if (e >= 0) begin
          r.ped = pp | m_walk(m);
          r.grant = '0;
          r.age = 0;
          if (e == m.road) begin r.kind = K_EMG; r.emg[e] = 1'b0; end
          else r.kind = K_YEL;
        end else if (last) begin
          r.kind = K_YEL; r.age = 0; r.grant = '0;
        end
      end
      K_YEL: if (last) begin r.kind = K_RED; r.age = 0; end
      K_RED: if (last) begin
        r.age = 0;
        if (e >= 0) begin
          r.kind = K_EMG; r.road = e; r.emg[e] = 1'b0;
        end else begin
          r.kind = K_GRN;
          r.road = (m.road + 1) % m.n;
          r.grant = pp;
          r.grant[r.road] = 1'b0;
          r.ped = pp & ~r.grant;
        end
      end
      default: begin
        r.emg[m.road] = 1'b0;
        if (e_in[m.road]) r.age = 0;
        else if (last) begin r.kind = K_YEL; r.age = 0; end
      end
    endcase
    return r;
  endfunction

  mdl_t m2, m4;
  int   edges = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m2    <= m_reset(2);
      m4    <= m_reset(4);
      edges <= 0;
    end else begin
      m2    <= m_step(m2, {2'b00, emg2}, {2'b00, ped2});
      m4    <= m_step(m4, emg4, ped4);
      edges <= edges + 1;
    end
  end

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [11:0] l,
                         input logic [3:0] w, input logic [3:0] b,
                         input logic [1:0] ar, input logic ea);
    int nonred, bad_walk;
    check($sformatf("%s e%0d lights", tag, edges), 32'(l), 32'(m_lights(m)));
    check($sformatf("%s e%0d walk", tag, edges), 32'(w), 32'(m_walk(m)));
    check($sformatf("%s e%0d buzzer", tag, edges), 32'(b), 32'(m_buzz(m)));
    check($sformatf("%s e%0d active_road", tag, edges), 32'(ar), 32'(m.road));
    check($sformatf("%s e%0d emg_active", tag, edges), 32'(ea), 32'(m.kind == K_EMG));
    nonred   = 0;
    bad_walk = 0;
    for (int i = 0; i < m.n; i++) begin
      if (l[3*i +: 3] != 3'b100) begin
        nonred++;
        if (w[i]) bad_walk++;
      end
    end
    check($sformatf("%s e%0d at_most_one_nonred", tag, edges), 32'(nonred <= 1), 32'd1);
    check($sformatf("%s e%0d walk_on_nonred", tag, edges), 32'(bad_walk), 32'd0);
  endtask

  always @(negedge clk) begin
    cmp_dut("n2", m2, {6'b0, l2}, {2'b0, w2}, {2'b0, b2}, {1'b0, ar2}, ea2);
    cmp_dut("n4", m4, l4, w4, b4, ar4, ea4);
  end

  // ---------------- directed stimulus ----------------
  // Wait for the negedge that follows posedge number k since reset release.
  task automatic goto(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (edges != k && guard < 200);
    if (edges != k) begin
      $display("FAIL goto: edge %0d never reached (at %0d)", k, edges);
      $fatal(1, "edge bound expired");
    end
  endtask

  task automatic reset_values(input string tag);
    check({tag, " l2"}, 32'(l2), 32'h24);       // 100_100
    check({tag, " l4"}, 32'(l4), 32'h924);      // 100_100_100_100
    check({tag, " ar2"}, 32'(ar2), 32'd1);
    check({tag, " ar4"}, 32'(ar4), 32'd3);
    check({tag, " walk"}, 32'({w2, w4}), 32'd0);
    check({tag, " buzzer"}, 32'({b2, b4}), 32'd0);
    check({tag, " emg_active"}, 32'({ea2, ea4}), 32'd0);
  endtask

  initial begin
    #0.2 reset = 1'b0;
    #0.6 reset_values("reset");
    #0.2 reset = 1'b1;                            // t = 1

    goto(1);  check("d1 l2 road0 green", 32'(l2), 32'b100_001);
              check("d1 ar2", 32'(ar2), 32'd0);
              check("d1 l4 road0 green", 32'(l4), 32'b100_100_100_001);
    goto(2);  ped2 = 2'b11;
    goto(4);  ped2 = 2'b00; emg4 = 4'b0011;
    goto(5);  emg4 = 4'b0000;
              check("d5 l4 emg in place", 32'(l4), 32'b100_100_100_001);
              check("d5 ea4", 32'(ea4), 32'd1);
    goto(10); check("d10 l2 last green", 32'(l2), 32'b100_001);
    goto(11); check("d11 l2 yellow", 32'(l2), 32'b100_010);
    goto(13); check("d13 l4 yellow after emg", 32'(l4), 32'b100_100_100_010);
              check("d13 ea4", 32'(ea4), 32'd0);
    goto(14); check("d14 l2 all red", 32'(l2), 32'b100_100);
    goto(15); check("d15 l2 road1 green", 32'(l2), 32'b001_100);
              check("d15 ar2", 32'(ar2), 32'd1);
              check("d15 walk2", 32'(w2), 32'b01);
              check("d15 buzz2", 32'(b2), 32'b00);
    goto(17); check("d17 l4 road1 emg", 32'(l4), 32'b100_100_001_100);
              check("d17 ar4", 32'(ar4), 32'd1);
              check("d17 ea4", 32'(ea4), 32'd1);
    goto(19); check("d19 walk2", 32'(w2), 32'b01);
              check("d19 buzz2", 32'(b2), 32'b01);
    goto(21); check("d21 walk2 over", 32'(w2), 32'b00);
              check("d21 buzz2 over", 32'(b2), 32'b00);
    goto(24); check("d24 walk2 road1 held", 32'(w2), 32'b00);
    goto(29); check("d29 l2 road0 green", 32'(l2), 32'b100_001);
              check("d29 walk2 road1 granted", 32'(w2), 32'b10);
              check("d29 l4 road2 green", 32'(l4), 32'b100_001_100_100);
              check("d29 ar4", 32'(ar4), 32'd2);
    goto(30); check("d30 walk2", 32'(w2), 32'b10);
              emg2 = 2'b01;
    goto(31); emg2 = 2'b00;
              check("d31 walk2 cancelled", 32'(w2), 32'b00);
              check("d31 buzz2", 32'(b2), 32'b00);
              check("d31 ea2", 32'(ea2), 32'd1);
              check("d31 l2 no yellow", 32'(l2), 32'b100_001);
    goto(38); check("d38 ea2 last emg", 32'(ea2), 32'd1);
    goto(39); check("d39 l2 yellow", 32'(l2), 32'b100_010);
              check("d39 ea2", 32'(ea2), 32'd0);
    goto(43); check("d43 l2 road1 green", 32'(l2), 32'b001_100);
              check("d43 walk2", 32'(w2), 32'b00);
    goto(57); check("d57 l2 road0 green", 32'(l2), 32'b100_001);
              check("d57 walk2 regrant", 32'(w2), 32'b10);
    goto(58); emg2 = 2'b10;
    goto(59); emg2 = 2'b00;
              check("d59 l2 preempt yellow", 32'(l2), 32'b100_010);
              check("d59 ar2", 32'(ar2), 32'd0);
              check("d59 walk2", 32'(w2), 32'b00);
    goto(62); check("d62 l2 all red", 32'(l2), 32'b100_100);
    goto(63); check("d63 l2 road1 emg", 32'(l2), 32'b001_100);
              check("d63 ea2", 32'(ea2), 32'd1);
              check("d63 ar2", 32'(ar2), 32'd1);
    goto(70); check("d70 ea2", 32'(ea2), 32'd1);
    goto(71); check("d71 l2 road1 yellow", 32'(l2), 32'b010_100);
              check("d71 ea2", 32'(ea2), 32'd0);
    goto(75); check("d75 l2 rotation road0", 32'(l2), 32'b100_001);
              check("d75 walk2", 32'(w2), 32'b10);
    goto(79); ped2 = 2'b01;
    goto(80); ped2 = 2'b00;
    goto(85); check("d85 l2 yellow", 32'(l2), 32'b100_010);
              emg2 = 2'b10;
    goto(86); emg2 = 2'b00;
    #2 reset = 1'b0;
    #1 reset_values("midreset");
    @(negedge clk);
    #1 reset = 1'b1;
    goto(1);  check("r1 l2 road0 green", 32'(l2), 32'b100_001);
              check("r1 ea2 lost", 32'(ea2), 32'd0);
              check("r1 ar2", 32'(ar2), 32'd0);
    goto(15); check("r15 l2 road1 green", 32'(l2), 32'b001_100);
              check("r15 walk2 lost", 32'(w2), 32'b00);
    goto(16);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_road_traffic_controller.md
Name: multi_road_traffic_controller

Overview:
- N-road generalisation of the two-road intersection controller.
- Serves roads round-robin: GREEN -> YELLOW -> ALL_RED -> next road.
- Adds parametrised phase durations, latched per-road pedestrian requests with walk/buzzer timing, and latched per-road emergency preemption with fixed priority.
- Top-level intersection block, driven by the 1 Hz system tick clock; one clock cycle equals one second.

Parameters:
- NUM_ROADS, 2, number of roads/approaches (>=2).
- GREEN_T, 10, normal green duration in cycles.
- YELLOW_T, 3, yellow duration in cycles.
- ALLRED_T, 1, all-red clearance duration in cycles.
- WALK_T, 6, walk duration in cycles (WALK_T <= GREEN_T).
- BUZZ_T, 2, buzzer duration in cycles, covering the final cycles of walk (BUZZ_T <= WALK_T).
- EMG_T, 8, emergency green duration in cycles.

Ports:
- clk  in  1  system clock, 1 cycle = 1 s.
- reset  in  1  asynchronous, active-low reset.
- emergency  in  NUM_ROADS  per-road emergency request; pulse or level.
- ped_button  in  NUM_ROADS  per-road pedestrian crossing request; pulse or level.
- lights  out  3*NUM_ROADS  per-road {red,yellow,green}; road i occupies bits [3i+2:3i].
- walk  out  NUM_ROADS  walk signal for crossing road i.
- buzzer  out  NUM_ROADS  audible warning in the last BUZZ_T cycles of walk[i].
- active_road  out  IDXW=$clog2(NUM_ROADS)  index of the road owning the current phase.
- emg_active  out  1  high while an emergency green is being served.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low.
- Reset values:
  - state = ALL_RED, active_road = NUM_ROADS-1, timer = ALLRED_T-1.
  - Every road's light = 3'b100. walk = 0, buzzer = 0, emg_active = 0.
  - ped_req = 0, emg_req = 0.
- Phase timing:
  - Every phase lasts exactly its T cycles.
  - On phase entry, timer loads T-1. It decrements each cycle. The phase exits on the cycle after timer==0.
  - After reset release: ALLRED_T cycles of all-red, then road 0 GREEN.
- States:
  - GREEN: road active_road = 3'b001; all other roads red.
  - YELLOW: active road = 3'b010.
  - ALL_RED: all roads red.
  - EMG_GREEN: like GREEN but runs EMG_T cycles and holds emg_active = 1.
- Normal sequence: GREEN(GREEN_T) -> YELLOW -> ALL_RED -> GREEN of (active_road+1) mod NUM_ROADS.
- Pedestrian requests:
  - ped_button[i] high on a clock edge sets ped_req[i].
  - On entry to a normal GREEN of road r, every ped_req[i] with i!=r is granted and cleared in that same cycle.
  - A granted walk[i] is high for the first WALK_T cycles of that GREEN.
  - buzzer[i] is high for the last BUZZ_T of those cycles.
  - ped_req[r] stays pending.
  - A press during an active walk[i] re-latches ped_req[i] for the next grant.
- Emergency requests:
  - emergency[i] high on an edge sets emg_req[i].
  - The served road e is the lowest index with emg_req set.
  - In normal GREEN of road != e: go to YELLOW on the next cycle. Walks are cancelled (walk/buzzer low) and their ped_req bits re-set. Then ALL_RED, then EMG_GREEN of road e.
  - In normal GREEN of road == e: convert to EMG_GREEN in place with timer = EMG_T-1. Lights stay unchanged and there is no yellow. Walks are cancelled as above.
  - In YELLOW or ALL_RED: finish the current phase; the next green is EMG_GREEN of e.
  - emg_req[e] clears on entry to EMG_GREEN.
  - During EMG_GREEN: a new emergency[e] restarts the timer. Requests on other roads stay latched and are served after EMG_GREEN -> YELLOW -> ALL_RED. No ped grants are issued in EMG_GREEN.
  - After EMG_GREEN with no pending emg_req, rotation resumes at (e+1) mod NUM_ROADS.
- Simultaneous events: the request latch is evaluated before the transition, so a button or emergency asserted on the exiting cycle is honoured at that transition.
- Safety invariant: at most one road non-red at any time. walk[i] is never high while road i is non-red.
- Reset mid-operation: immediate return to the reset values above.

Decomposition:
- Shared package traffic_pkg:
  - state enum/localparams: GREEN, YELLOW, ALL_RED, EMG_GREEN.
  - light codes: RED=3'b100, YEL=3'b010, GRN=3'b001.
  - priority-encoder function (lowest set index).
- One sub-module: tc_phase_timer. Loadable down-counter, width $clog2(max T), with a done flag.

Test Plan:
- Reset low then released at t=1 (defaults, N=2) -> road0 green cycles 2-11, yellow 12-14, all-red 15, road1 green from 16; all-red during reset.
- ped_button=2'b11 pulsed for 2 cycles during road0 green -> walk[1] not granted until road0's next green; walk[0] for 6 cycles at road1 green start; buzzer[0] in cycles 5-6 of that walk.
- emergency[1] pulse mid road0 green -> next cycle YELLOW(3), ALL_RED(1), road1 EMG_GREEN 8 cycles with emg_active=1, then rotation resumes at road0.
- emergency[0] during road0 green with walk[1] active -> no yellow; green extended 8 cycles; walk[1]/buzzer[1] drop immediately; ped_req[1] re-granted at next eligible green.
- emergency=2'b11 simultaneously, N=4 build -> road0 served first, then road1; no two roads non-red in any cycle (assertion).
- reset asserted mid-YELLOW -> all outputs at reset values asynchronously; pending ped/emg requests lost.
